data_mem_responder: RTL

Responder end of the MEM-stage data-memory interface. It accepts one load/store request per cycle over a valid/ready handshake and commits stores with byte-lane strobes decoded from funct3 and the address. Load data is returned one cycle later, already aligned and sign/zero-extended, through a registered response port with back-pressure. It replaces the combinational data RAM behind the memory stage, so the pipeline can tolerate a stalled or slow consumer.

---
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: registered load/store response port with valid/ready back-pressure.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_e;

  rsp_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  fire;
  logic                  retire;
  logic                  load_rsp;
  logic [ADDR_W-1:0]     word_idx;
  logic [1:0]            off_raw;
  logic [1:0]            off;
  logic                  is_half;
  logic                  is_word;
  logic                  illegal;
  logic                  acc_err;
  logic                  do_store;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  unused_addr_hi;

  assign rsp_valid_o = (state_q == RSP_FULL);
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign fire        = req_valid_i && req_ready_o;
  assign retire      = rsp_valid_o && rsp_ready_i;

  // Upper address bits are ignored so the array wraps.
  assign word_idx       = req_addr_i[ADDR_W+1:2];
  assign off_raw        = req_addr_i[1:0];
  assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:ADDR_W+2];

  assign is_half = (req_funct3_i[1:0] == 2'b01);
  assign is_word = (req_funct3_i[1:0] == 2'b10);
  assign illegal = req_we_i ? (req_funct3_i > 3'd2)
                            : ((req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign;
  assign misalign = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
  assign acc_err  = illegal || misalign;
  assign off      = off_raw;
`else
  assign acc_err  = illegal;
  assign off      = is_word ? 2'b00 : (is_half ? {off_raw[1], 1'b0} : off_raw);
`endif

  assign do_store = fire && req_we_i && !acc_err;

  always_comb begin
    be    = '0;
    wlane = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        wlane = {2{req_wdata_i[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = '0;
    endcase
  end

  // Gating on rst_n keeps a store that coincides with reset from committing.
  always_ff @(posedge clk) begin
    if (do_store && rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[8*off +: 8];
  assign half_sel = rd_word[16*off[1] +: 16];

  always_comb begin
    load_data = '0;
    case (req_funct3_i)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'b0, half_sel};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  assign rsp_data_d = (req_we_i || acc_err) ? '0 : load_data;

  always_comb begin
    state_d  = state_q;
    load_rsp = 1'b0;
    case (state_q)
      RSP_EMPTY: begin
        if (fire) begin
          state_d  = RSP_FULL;
          load_rsp = 1'b1;
        end
      end
      RSP_FULL: begin
        if (retire) begin
          if (fire) begin
            state_d  = RSP_FULL;
            load_rsp = 1'b1;
          end else begin
            state_d  = RSP_EMPTY;
          end
        end
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RSP_EMPTY;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_rsp) begin
        rsp_rdata_o <= rsp_data_d;
        rsp_err_o   <= acc_err;
      end
    end
  end

endmodule
